// File: rtl/imm_gen_stage.sv
// Registered RISC-V immediate generator with PC-relative target precompute.
// Ports: i_clk/i_reset, i_valid/i_instr/i_pc/i_imm_sel in; i_stall/i_flush control;
//        o_valid/o_imm/o_target/o_fmt/o_is_branch/o_is_jal/o_illegal out.
module imm_gen_stage #(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b1,
    parameter int PIPE_DEPTH  = 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic [3:0]      i_imm_sel,
    input  logic            i_stall,
    input  logic            i_flush,
    output logic            o_valid,
    output logic [XLEN-1:0] o_imm,
    output logic [XLEN-1:0] o_target,
    output logic [2:0]      o_fmt,
    output logic            o_is_branch,
    output logic            o_is_jal,
    output logic            o_illegal
);

    typedef enum logic [2:0] {
        F_NONE = 3'd0,
        F_I    = 3'd1,
        F_S    = 3'd2,
        F_B    = 3'd3,
        F_J    = 3'd4,
        F_U    = 3'd5,
        F_Z    = 3'd6
    } fmt_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        fmt_e            fmt;
        logic            illegal;
    } s1_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        fmt_e            fmt;
        logic            illegal;
    } out_t;

    fmt_e               fmt_d;
    logic               ill_d;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]    imm_d;

    always_comb begin
        fmt_d = F_NONE;
        ill_d = 1'b0;
        if (AUTO_DECODE) begin
            unique case (i_instr[6:0])
                7'b0010011,
                7'b0000011,
                7'b1100111: fmt_d = F_I;
                7'b1110011: fmt_d = i_instr[14] ? F_Z : F_I;
                7'b0100011: fmt_d = F_S;
                7'b1100011: fmt_d = F_B;
                7'b1101111: fmt_d = F_J;
                7'b0110111,
                7'b0010111: fmt_d = F_U;
                7'b0110011,
                7'b0111011: fmt_d = F_NONE;
                default:    ill_d = 1'b1;
            endcase
        end else begin
            unique case (i_imm_sel[3:2])
                2'b00: begin
                    unique case (i_imm_sel[1:0])
                        2'b00:   fmt_d = F_I;
                        2'b01:   fmt_d = F_S;
                        2'b10:   fmt_d = F_B;
                        default: fmt_d = F_NONE;
                    endcase
                end
                2'b01:   fmt_d = F_J;
                2'b10:   fmt_d = F_U;
                default: fmt_d = F_NONE;
            endcase
        end
    end

    // Every format fits in 32 bits; widening the signed value gives the
    // RV64 sign extension (Z is non-negative, so it zero-extends).
    always_comb begin
        imm32 = '0;
        unique case (fmt_d)
            F_I: imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            F_S: imm32 = {{20{i_instr[31]}}, i_instr[31:25],
                          i_instr[11:7]};
            F_B: imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                          i_instr[30:25], i_instr[11:8], 1'b0};
            F_J: imm32 = {{11{i_instr[31]}}, i_instr[31],
                          i_instr[19:12], i_instr[20],
                          i_instr[30:21], 1'b0};
            F_U: imm32 = {i_instr[31:12], 12'b0};
            F_Z: imm32 = {27'b0, i_instr[19:15]};
            default: imm32 = '0;
        endcase
        imm_d = XLEN'(imm32);
    end

    out_t src;
    out_t out_q;

    generate
        if (PIPE_DEPTH == 1) begin : g_d1
            assign src.valid   = i_valid;
            assign src.imm     = imm_d;
            assign src.target  = i_pc + imm_d;
            assign src.fmt     = fmt_d;
            assign src.illegal = ill_d;
        end else begin : g_d2
            s1_t s1_q;

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    s1_q <= '0;
                end else if (i_flush) begin
                    s1_q <= '0;
                end else if (!i_stall) begin
                    if (i_valid) begin
                        s1_q <= '{valid: 1'b1, imm: imm_d, pc: i_pc,
                                  fmt: fmt_d, illegal: ill_d};
                    end else begin
                        s1_q <= '0;
                    end
                end
            end

            // An empty stage-1 entry is all zero, so its target is zero too.
            assign src.valid   = s1_q.valid;
            assign src.imm     = s1_q.imm;
            assign src.target  = s1_q.pc + s1_q.imm;
            assign src.fmt     = s1_q.fmt;
            assign src.illegal = s1_q.illegal;
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            out_q <= '0;
        end else if (i_flush) begin
            out_q <= '0;
        end else if (!i_stall) begin
            out_q <= src.valid ? src : '0;
        end
    end

    assign o_valid     = out_q.valid;
    assign o_imm       = out_q.imm;
    assign o_target    = out_q.target;
    assign o_fmt       = out_q.fmt;
    assign o_is_branch = (out_q.fmt == F_B);
    assign o_is_jal    = (out_q.fmt == F_J);
    assign o_illegal   = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: four configurations driven in lock-step,
// checked each cycle against a format-rule model plus literal vectors.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        vin = 1'b0;
    logic [31:0] instr = '0;
    logic [63:0] pc = '0;
    logic [3:0]  sel = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    logic        v1, v2, v3, v4;
    logic [31:0] imm1, tg1, imm2, tg2, imm4, tg4;
    logic [63:0] imm3, tg3;
    logic [2:0]  f1, f2, f3, f4;
    logic        br1, br2, br3, br4;
    logic        j1, j2, j3, j4;
    logic        il1, il2, il3, il4;

    imm_gen_stage #(.XLEN(32), .AUTO_DECODE(1'b1), .PIPE_DEPTH(1)) u1 (
        .i_clk(clk), .i_reset(rst), .i_valid(vin), .i_instr(instr),
        .i_pc(pc[31:0]), .i_imm_sel(sel), .i_stall(stall),
        .i_flush(flush), .o_valid(v1), .o_imm(imm1), .o_target(tg1),
        .o_fmt(f1), .o_is_branch(br1), .o_is_jal(j1), .o_illegal(il1));

    imm_gen_stage #(.XLEN(32), .AUTO_DECODE(1'b1), .PIPE_DEPTH(2)) u2 (
        .i_clk(clk), .i_reset(rst), .i_valid(vin), .i_instr(instr),
        .i_pc(pc[31:0]), .i_imm_sel(sel), .i_stall(stall),
        .i_flush(flush), .o_valid(v2), .o_imm(imm2), .o_target(tg2),
        .o_fmt(f2), .o_is_branch(br2), .o_is_jal(j2), .o_illegal(il2));

    imm_gen_stage #(.XLEN(64), .AUTO_DECODE(1'b1), .PIPE_DEPTH(2)) u3 (
        .i_clk(clk), .i_reset(rst), .i_valid(vin), .i_instr(instr),
        .i_pc(pc), .i_imm_sel(sel), .i_stall(stall),
        .i_flush(flush), .o_valid(v3), .o_imm(imm3), .o_target(tg3),
        .o_fmt(f3), .o_is_branch(br3), .o_is_jal(j3), .o_illegal(il3));

    imm_gen_stage #(.XLEN(32), .AUTO_DECODE(1'b0), .PIPE_DEPTH(1)) u4 (
        .i_clk(clk), .i_reset(rst), .i_valid(vin), .i_instr(instr),
        .i_pc(pc[31:0]), .i_imm_sel(sel), .i_stall(stall),
        .i_flush(flush), .o_valid(v4), .o_imm(imm4), .o_target(tg4),
        .o_fmt(f4), .o_is_branch(br4), .o_is_jal(j4), .o_illegal(il4));

    typedef struct {
        bit          v;
        logic [63:0] imm;
        logic [63:0] pc;
        int          fmt;
        bit          ill;
    } ment_t;

    int    xl [4] = '{32, 32, 64, 32};
    bit    au [4] = '{1, 1, 1, 0};
    int    dp [4] = '{1, 2, 2, 1};
    ment_t m  [4][2];

    function automatic ment_t zero_ent();
        ment_t e;
        e.v = 0; e.imm = '0; e.pc = '0; e.fmt = 0; e.ill = 0;
        return e;
    endfunction

    function automatic logic [63:0] mask(int k);
        return (xl[k] == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    endfunction

    // Format from opcode or selector, immediate from the ISA bit rules.
    function automatic ment_t ref_ent(int k);
        ment_t  e;
        longint s;
        longint r;
        logic [6:0] op;
        e = zero_ent();
        e.v = 1;
        op = instr[6:0];
        if (au[k]) begin
            case (op)
                7'h13, 7'h03, 7'h67: e.fmt = 1;
                7'h73:               e.fmt = instr[14] ? 6 : 1;
                7'h23:               e.fmt = 2;
                7'h63:               e.fmt = 3;
                7'h6F:               e.fmt = 4;
                7'h37, 7'h17:        e.fmt = 5;
                7'h33, 7'h3B:        e.fmt = 0;
                default: begin e.fmt = 0; e.ill = 1; end
            endcase
        end else begin
            if (sel == 4'd0) e.fmt = 1;
            else if (sel == 4'd1) e.fmt = 2;
            else if (sel == 4'd2) e.fmt = 3;
            else if (sel >= 4'd4 && sel <= 4'd7) e.fmt = 4;
            else if (sel >= 4'd8 && sel <= 4'd11) e.fmt = 5;
            else e.fmt = 0;
        end
        s = longint'(signed'(instr));
        case (e.fmt)
            1: r = s >>> 20;
            2: r = ((s >>> 25) <<< 5) + longint'(instr[11:7]);
            3: r = ((s >>> 31) <<< 12) + (longint'(instr[7]) << 11)
                 + (longint'(instr[30:25]) << 5)
                 + (longint'(instr[11:8]) << 1);
            4: r = ((s >>> 31) <<< 20) + (longint'(instr[19:12]) << 12)
                 + (longint'(instr[20]) << 11)
                 + (longint'(instr[30:21]) << 1);
            5: r = (s >>> 12) <<< 12;
            6: r = longint'(instr[19:15]);
            default: r = 0;
        endcase
        e.imm = r & mask(k);
        e.pc  = pc & mask(k);
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            for (int k = 0; k < 4; k++) begin
                m[k][0] <= zero_ent();
                m[k][1] <= zero_ent();
            end
        end else if (!stall) begin
            for (int k = 0; k < 4; k++) begin
                m[k][1] <= m[k][0];
                m[k][0] <= vin ? ref_ent(k) : zero_ent();
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp(input int k, input logic v, input logic [63:0] imm,
                       input logic [63:0] tg, input logic [2:0] f,
                       input logic br, input logic j, input logic il);
        ment_t e;
        logic [134:0] act, exp;
        e = m[k][dp[k]-1];
        act = {v, imm, tg, f, br, j, il};
        exp = {e.v, e.imm, (e.pc + e.imm) & mask(k), 3'(e.fmt),
               e.fmt == 3, e.fmt == 4, e.ill};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model_u%0d: got %h expected %h", k + 1, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cmp(0, v1, {32'b0, imm1}, {32'b0, tg1}, f1, br1, j1, il1);
        cmp(1, v2, {32'b0, imm2}, {32'b0, tg2}, f2, br2, j2, il2);
        cmp(2, v3, imm3, tg3, f3, br3, j3, il3);
        cmp(3, v4, {32'b0, imm4}, {32'b0, tg4}, f4, br4, j4, il4);
    end

    task automatic step(input logic [31:0] ins, input logic [63:0] p,
                        input logic [3:0] s, input bit v,
                        input bit st, input bit fl);
        @(negedge clk);
        instr = ins; pc = p; sel = s; vin = v; stall = st; flush = fl;
    endtask

    task automatic idle();
        step(32'h0, 64'h0, 4'h0, 0, 0, 0);
    endtask

    logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                             7'h6F, 7'h37, 7'h17, 7'h33, 7'h3B, 7'h7F};

    initial begin
        rst = 1'b1;
        idle();
        idle();
        chk("reset_valid", {60'b0, v1, v2, v3, v4}, 64'h0);
        chk("reset_imm3", imm3, 64'h0);
        rst = 1'b0;

        step(32'hFFF00093, 64'h100, 4'h0, 1, 0, 0);
        idle();
        chk("addi_imm", imm1, 64'hFFFFFFFF);
        chk("addi_fmt_br", {f1, br1, v1}, {3'd1, 1'b0, 1'b1});
        chk("addi_tgt", tg1, 64'h000000FF);

        step(32'hFE000CE3, 64'h200, 4'h0, 1, 0, 0);
        idle();
        chk("beq_imm", imm1, 64'hFFFFFFF8);
        chk("beq_fmt_br", {f1, br1}, {3'd3, 1'b1});
        chk("beq_tgt", tg1, 64'h000001F8);

        step(32'h001000EF, 64'h1000, 4'h0, 1, 0, 0);
        idle();
        chk("jal_imm", imm1, 64'h800);
        chk("jal_flag", {j1, f1}, {1'b1, 3'd4});
        chk("jal_tgt", tg1, 64'h1800);

        step(32'h123452B7, 64'h0, 4'h0, 1, 0, 0);
        idle();
        chk("lui_imm", imm1, 64'h12345000);
        chk("lui_fmt", f1, 64'd5);

        step(32'h800002B7, 64'h0, 4'h0, 1, 0, 0);
        idle();
        chk("lui80_imm32", imm1, 64'h80000000);
        idle();
        chk("lui80_imm64", imm3, 64'hFFFFFFFF_80000000);

        step(32'h00112623, 64'h0, 4'h1, 1, 0, 0);
        idle();
        chk("sw_manual_imm", imm4, 64'd12);
        chk("sw_manual_fmt", f4, 64'd2);

        step(32'h0000007F, 64'h0, 4'h0, 1, 0, 0);
        idle();
        chk("illegal_flag", {il1, f1}, {1'b1, 3'd0});
        chk("illegal_imm", imm1, 64'h0);

        step(32'h3002D073, 64'h0, 4'h0, 1, 0, 0);
        idle();
        chk("csr_fmt", f1, 64'd6);
        chk("csr_imm", imm1, 64'd5);

        step(32'hFE000CE3, 64'h200, 4'h0, 1, 0, 0);
        idle();
        step(32'h0, 64'h0, 4'h0, 0, 1, 0);
        chk("stall_first", {v2, imm2}, {1'b1, 32'hFFFFFFF8});
        for (int i = 0; i < 2; i++) begin
            step(32'h0, 64'h0, 4'h0, 0, 1, 0);
            chk("stall_hold", {v2, imm2, tg2}, {1'b1, 32'hFFFFFFF8,
                                                32'h1F8});
        end
        idle();
        chk("stall_last", {v2, br2}, {1'b1, 1'b1});
        idle();
        chk("stall_once", v2, 64'd0);

        step(32'hFE000CE3, 64'h200, 4'h0, 1, 0, 0);
        step(32'hFE000CE3, 64'h200, 4'h0, 1, 1, 1);
        chk("pre_flush", v1, 64'd1);
        idle();
        chk("flush_v", {v1, v2, v3}, 64'd0);
        idle();
        chk("flush_s1", {v2, v3}, 64'd0);

        step(32'hFFF00093, 64'h100, 4'h0, 1, 0, 0);
        step(32'hFFF00093, 64'h100, 4'h0, 1, 0, 0);
        step(32'hFFF00093, 64'h100, 4'h0, 1, 0, 0);
        chk("pre_reset", {v1, v2}, 64'd3);
        #2 rst = 1'b1;
        #1 chk("async_reset", {v1, v2, v3, v4}, 64'd0);
        idle();
        idle();
        rst = 1'b0;
        step(32'hFE000CE3, 64'h200, 4'h0, 1, 0, 0);
        idle();
        chk("post_rst_1", v2, 64'd0);
        idle();
        chk("post_rst_2", {v2, imm2}, {1'b1, 32'hFFFFFFF8});

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            r = $urandom;
            rst = ($urandom_range(0, 99) == 0);
            step({r[31:7], ops[$urandom_range(0, 11)]},
                 {$urandom, $urandom}, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 6) == 0,
                 $urandom_range(0, 19) == 0);
        end
        rst = 1'b0;
        idle();
        idle();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered, parametrised immediate-generation stage for the decode pipe.
- Builds the XLEN-wide immediate and can classify the format from the opcode itself.
- Precomputes PC + imm so branch and jump targets are ready for the 2-bit predictor's early redirect.
- Carries a valid bit with stall/flush control so it drops into the ID stage without extra glue.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- AUTO_DECODE, 1:
  - 1: format is derived from opcode.
  - 0: format comes from i_imm_sel using the legacy 4-bit encoding.
- PIPE_DEPTH, 1, register stages from input to output; legal values 1 or 2.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  input instruction valid
- i_instr  in  32  instruction word
- i_pc  in  XLEN  PC of the instruction
- i_imm_sel  in  4  used only when AUTO_DECODE=0: 00_00 I, 00_01 S, 00_10 B, 01_xx J, 10_xx U, 11_xx zero
- i_stall  in  1  hold all stages
- i_flush  in  1  kill all in-flight entries
- o_valid  out  1  output entry valid
- o_imm  out  XLEN  sign/zero-extended immediate
- o_target  out  XLEN  i_pc + o_imm, modulo 2^XLEN
- o_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 J, 5 U, 6 Z (CSR zimm)
- o_is_branch  out  1  fmt==B
- o_is_jal  out  1  fmt==J
- o_illegal  out  1  unrecognised opcode (AUTO_DECODE=1 only)

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset is asynchronous and active-high.
  - While reset is asserted, every output and every internal stage register is 0.
  - o_valid drops in the same instant reset asserts; it does not wait for a clock edge.
- Auto-decode map (opcode bits 6:0):
  - 0010011, 0000011, 1100111 → I.
  - 1110011: Z if funct3[2]=1, else I.
  - 0100011 → S.
  - 1100011 → B.
  - 1101111 → J.
  - 0110111, 0010111 → U.
  - 0110011, 0111011 → NONE, o_illegal=0.
  - Any other opcode → NONE with o_illegal=1.
- Format rules:
  - I: instr[31:20], sign-extended.
  - S: {instr[31:25], instr[11:7]}, sign-extended.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
  - U: {instr[31:12], 12'b0}, sign-extended from bit 31 to XLEN (RV64 LUI semantics).
  - Z: instr[19:15], zero-extended.
  - NONE: 0.
- Manual mode (AUTO_DECODE=0):
  - o_fmt is mapped from i_imm_sel.
  - Encoding 11_xx gives NONE with imm 0.
  - o_illegal is held at 0.
- Target: o_target is always i_pc + o_imm, with carry-out discarded. It is meaningful only when o_is_branch or o_is_jal is 1.
- Latency: input sampled on edge N appears on outputs after edge N+PIPE_DEPTH−1 (registered).
  - PIPE_DEPTH=1: all outputs are registered once; the target adder is in the same stage.
  - PIPE_DEPTH=2: stage 1 registers imm, fmt, pc and valid; stage 2 adds and registers o_target plus the rest.
- Stall (i_stall=1, i_flush=0): every stage holds its contents. Inputs presented that cycle are ignored, and the upstream stage must re-present them.
- Flush:
  - i_flush=1 clears the valid bit of every stage on the next edge.
  - Data fields of flushed stages load 0.
  - Flush has priority over stall.
  - An i_valid input in the flush cycle is discarded.
- Invalid input: when i_valid=0 and not stalled, the stage loads valid=0 and data fields 0. Outputs are therefore 0 whenever o_valid=0.
- Reset during operation: all in-flight entries are lost. First valid output appears PIPE_DEPTH edges after the first valid input following reset release.

Test Plan:
- addi x1,x0,−1 (0xFFF00093), pc 0x100, XLEN=32, PIPE_DEPTH=1 → next cycle: o_valid=1, o_imm=0xFFFFFFFF, o_fmt=1, o_target=0x000000FF, o_is_branch=0.
- beq x0,x0,−8 (0xFE000CE3), pc 0x200 → o_imm=0xFFFFFFF8, o_fmt=3, o_is_branch=1, o_target=0x000001F8.
- jal x1,+2048 (0x001000EF), pc 0x1000 → o_imm=0x00000800, o_is_jal=1, o_target=0x00001800.
- lui x5,0x12345 (0x123452B7) → o_imm=0x12345000, o_fmt=5.
  - XLEN=64, instr 0x800002B7 → o_imm=0xFFFFFFFF80000000.
- AUTO_DECODE=0, i_imm_sel=0001, sw x1,12(x2) (0x00112623) → o_imm=12, o_fmt=2.
  - Opcode 0x7F with AUTO_DECODE=1 → o_illegal=1, o_imm=0.
  - csrrwi x0,mstatus,5 (0x3002D073) → o_fmt=6, o_imm=5.
- Control and reset, PIPE_DEPTH=2:
  - Valid beq is held by i_stall for 3 cycles → outputs unchanged, entry delivered once.
  - i_stall and i_flush asserted together → o_valid=0 on next edge.
  - i_reset pulsed mid-stream with no clock edge → o_valid=0 immediately.
  - After release: first valid output 2 edges after first valid input.
